alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps an external ALU through operand loads from switches using a
// debounced advance button, then captures the ALU result and flags for display.
//
// Flow: LOAD_A --press--> LOAD_B --press--> EXEC --(1 cycle)--> SHOW --press--> LOAD_A
// The raw button is synchronised, debounced and edge-detected. Only a 0->1 change of
// the debounced level creates a press.

module alu_sequencer #(
    parameter int unsigned M   = 4,  // operand and result width
    parameter int unsigned DEB = 4   // stable cycles needed to accept a level change (1..255)
) (
    input  logic         clk,
    input  logic         rst,        // synchronous, active low
    input  logic [M-1:0] SW,
    input  logic         BTN,
    output logic [M-1:0] A,
    output logic [M-1:0] B,
    input  logic [M-1:0] R_IN,
    input  logic         C_IN,
    input  logic         N_IN,
    input  logic         V_IN,
    input  logic         Z_IN,
    output logic [M-1:0] R,
    output logic         C,
    output logic         N,
    output logic         V,
    output logic         Z,
    output logic         VALID,
    output logic [1:0]   STATE
);

    typedef enum logic [1:0] {
        StLoadA = 2'b00,
        StLoadB = 2'b01,
        StExec  = 2'b10,
        StShow  = 2'b11
    } state_t;

    // Terminal count for both debounce counters: DEB stable cycles counted as 0..DEB-1.
    localparam logic [7:0] DebMax = 8'(DEB - 1);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic       r_sync1;
    logic       r_sync2;
    logic       r_deb;        // debounced button level
    logic       r_deb_prev;   // debounced level one cycle ago, for rise detection
    logic [7:0] r_cnt;        // cycles the synchronised level has differed from r_deb
    logic       r_block;      // set by reset until the button is seen stably released
    logic [7:0] r_arm_cnt;    // stable-low cycles seen while blocked
    logic       w_press;

    // Two-flop synchroniser; nothing else ever looks at the raw BTN pin.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= BTN;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level only after DEB consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_deb      <= 1'b0;
            r_deb_prev <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_deb_prev <= r_deb;
            if (r_sync2 != r_deb) begin
                if (r_cnt == DebMax) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                // Any excursion shorter than DEB restarts the count.
                r_cnt <= '0;
            end
        end
    end

    // Post-reset lockout: a button held through reset must be released (stably low for
    // DEB cycles) before any press is honoured.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_block   <= 1'b1;
            r_arm_cnt <= '0;
        end else if (r_block) begin
            if (!r_sync2 && !r_deb) begin
                if (r_arm_cnt == DebMax) begin
                    r_block   <= 1'b0;
                    r_arm_cnt <= '0;
                end else begin
                    r_arm_cnt <= r_arm_cnt + 8'd1;
                end
            end else begin
                r_arm_cnt <= '0;
            end
        end
    end

    // One-cycle press pulse in the first cycle the debounced level reads high.
    assign w_press = r_deb & ~r_deb_prev & ~r_block;

    // ------------------------------------------------------------------
    // Sequencer FSM and datapath registers
    // ------------------------------------------------------------------
    state_t       r_state;
    state_t       w_state_next;
    logic [M-1:0] r_a;
    logic [M-1:0] w_a_next;
    logic [M-1:0] r_b;
    logic [M-1:0] w_b_next;
    logic [M-1:0] r_r;
    logic [M-1:0] w_r_next;
    logic [3:0]   r_flags;    // {C, N, V, Z}
    logic [3:0]   w_flags_next;
    logic         r_valid;
    logic         w_valid_next;

    // State and datapath registers; reset wins over everything, including EXEC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StLoadA;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_flags <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_r     <= w_r_next;
            r_flags <= w_flags_next;
            r_valid <= w_valid_next;
        end
    end

    // Next-state and register updates; everything holds unless a press or EXEC acts.
    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_r_next     = r_r;
        w_flags_next = r_flags;
        w_valid_next = r_valid;
        case (r_state)
            StLoadA: begin
                if (w_press) begin
                    w_a_next     = SW;
                    w_state_next = StLoadB;
                end
            end
            StLoadB: begin
                if (w_press) begin
                    w_b_next     = SW;
                    w_state_next = StExec;
                end
            end
            StExec: begin
                // A press landing here is dropped, never queued.
                w_r_next     = R_IN;
                w_flags_next = {C_IN, N_IN, V_IN, Z_IN};
                w_valid_next = 1'b1;
                w_state_next = StShow;
            end
            StShow: begin
                if (w_press) begin
                    w_valid_next = 1'b0;
                    w_state_next = StLoadA;
                end
            end
            default: begin
                w_state_next = StLoadA;
            end
        endcase
    end

    assign A     = r_a;
    assign B     = r_b;
    assign R     = r_r;
    assign C     = r_flags[3];
    assign N     = r_flags[2];
    assign V     = r_flags[1];
    assign Z     = r_flags[0];
    assign VALID = r_valid;
    assign STATE = r_state;

endmodule
